// File: rtl/tile_io_sequencer.sv
// tile_io_sequencer: drives LFSR vectors into a microtile and folds its responses into a 16-bit MISR.
//    Ports: clk/rst (sync, active-high); start/seed/vec_count launch a run of N vectors
//    (seed 0 -> 1, vec_count 0 -> 256); tile_ui drives the tile, tile_uo is its response;
//    busy spans SETTLE/CAPTURE, done pulses once at the end, signature and last_uo hold results.
//    Optional TILE_SEQ_COMPARE_EN adds expected_sig input and pass output.
module tile_io_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [15:0] SIG_INIT = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  seed,
   input  logic [7:0]  vec_count,
   output logic [7:0]  tile_ui,
   input  logic [7:0]  tile_uo,
   output logic        busy,
   output logic        done,
   output logic [15:0] signature,
   output logic [7:0]  last_uo
`ifdef TILE_SEQ_COMPARE_EN
   ,
   input  logic [15:0] expected_sig,
   output logic        pass
`endif
);
   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;
   localparam logic [7:0] SETTLE_RELOAD = SETTLE_CYCLES[7:0];
   // With no settle time the vector is captured on the very next cycle.
   localparam state_t FIRST_ST = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
   state_t      state_q, state_d;
   logic [7:0]  tile_ui_q, tile_ui_d;
   logic [15:0] sig_q, sig_d;
   logic [7:0]  last_uo_q, last_uo_d;
   logic [8:0]  rem_q, rem_d;
   logic [7:0]  settle_q, settle_d;
   logic [15:0] misr_next;
   logic [7:0]  lfsr_next;
`ifdef TILE_SEQ_COMPARE_EN
   logic        pass_q, pass_d;
`endif
   assign misr_next = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3]} ^ {8'h00, tile_uo};
   assign lfsr_next = {tile_ui_q[6:0], tile_ui_q[7] ^ tile_ui_q[5] ^ tile_ui_q[4] ^ tile_ui_q[3]};
   always_comb begin
      state_d   = state_q;
      tile_ui_d = tile_ui_q;
      sig_d     = sig_q;
      last_uo_d = last_uo_q;
      rem_d     = rem_q;
      settle_d  = settle_q;
`ifdef TILE_SEQ_COMPARE_EN
      pass_d    = pass_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               tile_ui_d = (seed == 8'h00) ? 8'h01 : seed;
               sig_d     = SIG_INIT;
               rem_d     = (vec_count == 8'h00) ? 9'd256 : {1'b0, vec_count};
               settle_d  = SETTLE_RELOAD;
               state_d   = FIRST_ST;
`ifdef TILE_SEQ_COMPARE_EN
               pass_d    = 1'b0;
`endif
            end
         end
         SETTLE: begin
            settle_d = settle_q - 8'd1;
            state_d  = (settle_q <= 8'd1) ? CAPTURE : SETTLE;
         end
         CAPTURE: begin
            sig_d     = misr_next;
            last_uo_d = tile_uo;
            rem_d     = rem_q - 9'd1;
            if (rem_q == 9'd1) begin
               state_d = DONE;
`ifdef TILE_SEQ_COMPARE_EN
               pass_d  = (misr_next == expected_sig);
`endif
            end else begin
               tile_ui_d = lfsr_next;
               settle_d  = SETTLE_RELOAD;
               state_d   = FIRST_ST;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tile_ui_q <= 8'h00;
         sig_q     <= SIG_INIT;
         last_uo_q <= 8'h00;
         rem_q     <= 9'd0;
         settle_q  <= 8'd0;
`ifdef TILE_SEQ_COMPARE_EN
         pass_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         tile_ui_q <= tile_ui_d;
         sig_q     <= sig_d;
         last_uo_q <= last_uo_d;
         rem_q     <= rem_d;
         settle_q  <= settle_d;
`ifdef TILE_SEQ_COMPARE_EN
         pass_q    <= pass_d;
`endif
      end
   end
   assign tile_ui   = tile_ui_q;
   assign signature = sig_q;
   assign last_uo   = last_uo_q;
   assign busy      = (state_q == SETTLE) || (state_q == CAPTURE);
   assign done      = (state_q == DONE);
`ifdef TILE_SEQ_COMPARE_EN
   assign pass      = pass_q;
`endif
endmodule

// File: tb/tb_tile_io_sequencer.sv
// tb_tile_io_sequencer: randomized and directed runs checked against a cycle-level model of the sequencer rules.
module tb_tile_io_sequencer;
   localparam int SC = 2;
   localparam int P = SC + 1;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  seed = 8'h00;
   logic [7:0]  vec_count = 8'h00;
   logic [7:0]  tile_ui;
   logic [7:0]  tile_uo = 8'h00;
   logic        busy;
   logic        done;
   logic [15:0] signature;
   logic [7:0]  last_uo;
   logic [15:0] expected_sig = 16'h0000;
   int          total = 0;
   int          passed = 0;
`ifdef TILE_SEQ_COMPARE_EN
   logic        pass;
`endif
   tile_io_sequencer #(.SETTLE_CYCLES(SC), .SIG_INIT(16'hFFFF)) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .vec_count(vec_count),
      .tile_ui(tile_ui), .tile_uo(tile_uo), .busy(busy), .done(done),
      .signature(signature), .last_uo(last_uo)
`ifdef TILE_SEQ_COMPARE_EN
      , .expected_sig(expected_sig), .pass(pass)
`endif
   );
   always #5 clk = ~clk;
   function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] u);
      return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {8'h00, u};
   endfunction
   function automatic logic [7:0] lfsr(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   task automatic check_idle_reset();
      chk("rst_tile_ui", {8'h00, tile_ui}, 16'h0000);
      chk("rst_busy", {15'h0, busy}, 16'h0);
      chk("rst_done", {15'h0, done}, 16'h0);
      chk("rst_sig", signature, 16'hFFFF);
      chk("rst_last_uo", {8'h00, last_uo}, 16'h0000);
   endtask
   // One run: the model tracks the applied vector, capture edges and MISR per cycle.
   task automatic run(input logic [7:0] sd, input logic [7:0] cnt, input bit rnd,
                      input logic [7:0] uo_fix, input int abort_k, input logic [15:0] exp_sig);
      logic [7:0]  v;
      logic [15:0] s;
      logic [7:0]  last;
      int          n, nv, tot;
      v = (sd == 8'h00) ? 8'h01 : sd;
      s = 16'hFFFF;
      last = 8'h00;
      n = 0;
      nv = (cnt == 8'h00) ? 256 : int'(cnt);
      tot = nv * P;
      @(negedge clk);
      start = 1'b1;
      seed = sd;
      vec_count = cnt;
      expected_sig = exp_sig;
      tile_uo = rnd ? 8'($urandom) : uo_fix;
      @(posedge clk);
      for (int k = 1; k <= tot; k++) begin
         @(negedge clk);
         start = (k == 2) && (abort_k == 0);
         seed = 8'h3C;
         vec_count = 8'd7;
         chk("tile_ui", {8'h00, tile_ui}, {8'h00, v});
         chk("busy", {15'h0, busy}, 16'h1);
         chk("done_early", {15'h0, done}, 16'h0);
         chk("sig_run", signature, s);
         if (k == abort_k) begin
            start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            check_idle_reset();
            rst = 1'b0;
            repeat (P + 1) begin
               @(negedge clk);
               chk("abort_no_done", {15'h0, done}, 16'h0);
               chk("abort_idle", {15'h0, busy}, 16'h0);
            end
            return;
         end
         tile_uo = rnd ? 8'($urandom) : uo_fix;
         @(posedge clk);
         if (k % P == 0) begin
            s = misr(s, tile_uo);
            last = tile_uo;
            n++;
            if (n < nv) v = lfsr(v);
         end
      end
      @(negedge clk);
      start = 1'b1;
      chk("done", {15'h0, done}, 16'h1);
      chk("busy_done", {15'h0, busy}, 16'h0);
      chk("sig_final", signature, s);
      chk("last_uo", {8'h00, last_uo}, {8'h00, last});
      chk("tile_ui_final", {8'h00, tile_ui}, {8'h00, v});
`ifdef TILE_SEQ_COMPARE_EN
      chk("pass", {15'h0, pass}, {15'h0, s == exp_sig});
`endif
      @(negedge clk);
      start = 1'b0;
      chk("done_pulse", {15'h0, done}, 16'h0);
      chk("start_in_done_ignored", {15'h0, busy}, 16'h0);
      chk("sig_hold", signature, s);
      chk("tile_ui_hold", {8'h00, tile_ui}, {8'h00, v});
   endtask
   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_reset();
      rst = 1'b0;
      run(8'h00, 8'd1, 1'b0, 8'h00, 0, 16'hFFFE);
      chk("zero_sig", signature, 16'hFFFE);
      chk("zero_last", {8'h00, last_uo}, 16'h0000);
      chk("zero_tile_ui", {8'h00, tile_ui}, 16'h0001);
      run(8'h00, 8'd1, 1'b0, 8'h5A, 0, 16'hFFA4);
      chk("resp_sig", signature, 16'hFFA4);
      chk("resp_last", {8'h00, last_uo}, 16'h005A);
      run(8'h00, 8'd1, 1'b0, 8'h5A, 0, 16'h0000);
      run(8'h01, 8'd5, 1'b1, 8'h00, 0, 16'h1234);
      chk("seq_last_vec", {8'h00, tile_ui}, 16'h0011);
      run(8'hA5, 8'd0, 1'b1, 8'h00, 0, 16'h0000);
      chk("wrap_vec", {8'h00, tile_ui}, 16'h00A5);
      run(8'h77, 8'd5, 1'b1, 8'h00, 2 * P + 2, 16'h0000);
      for (int i = 0; i < 5; i++)
         run(8'($urandom), 8'($urandom_range(1, 12)), 1'b1, 8'h00, 0, 16'($urandom));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/tile_io_sequencer.md
Name: tile_io_sequencer

Overview:
- Stimulus/response engine for the far side of a microtile's `ui_in`/`uo_out` interface.
- Drives pseudo-random 8-bit vectors into the tile input bus and waits a fixed settle time.
- Samples the tile output bus and compresses the responses into a 16-bit MISR signature.
- Used on-chip or in benches to self-check combinational/sequential microtiles without a host driving every pin.

Parameters:
- SETTLE_CYCLES, 2, cycles a vector is held before its response is sampled (0..255; 0 = sample on the cycle after apply).
- SIG_INIT, 16'hFFFF, MISR initial value loaded at reset and at every start.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE
- seed  input  8  LFSR start value; 8'h00 is replaced by 8'h01
- vec_count  input  8  number of vectors; 0 means 256
- tile_ui  output  8  registered drive to tile ui_in
- tile_uo  input  8  tile uo_out response
- busy  output  1  high while a run is in progress (SETTLE/CAPTURE)
- done  output  1  one-cycle pulse when the run completes
- signature  output  16  MISR value; valid from done until next start
- last_uo  output  8  last captured tile_uo value

Behaviour:
- Reset (rst=1 at edge): state IDLE, tile_ui=0, busy=0, done=0, signature=SIG_INIT, last_uo=0, internal counters 0. Reset mid-run aborts immediately; no done pulse.
- States: IDLE, SETTLE, CAPTURE, DONE. busy = (state==SETTLE || state==CAPTURE), decoded from registered state.
- IDLE: on start=1 at edge:
  - tile_ui <= (seed==0 ? 8'h01 : seed);
  - signature <= SIG_INIT;
  - remaining <= vec_count (0 = 256; use a 9-bit counter);
  - settle counter <= SETTLE_CYCLES;
  - go to SETTLE, or to CAPTURE if SETTLE_CYCLES==0.
- SETTLE: decrement the settle counter each cycle; when it reaches 1, go to CAPTURE. Net effect: SETTLE_CYCLES cycles are spent in SETTLE.
- CAPTURE (one cycle), at its closing edge:
  - signature <= {sig[14:0], sig[15]^sig[14]^sig[12]^sig[3]} ^ {8'h00, tile_uo};
  - last_uo <= tile_uo;
  - remaining <= remaining-1;
  - if remaining==1: go to DONE and leave tile_ui unchanged;
  - else: tile_ui <= LFSR next, reload the settle counter, go to SETTLE (or CAPTURE if SETTLE_CYCLES==0).
- Vector period is SETTLE_CYCLES+1 cycles. Vector n (0-based) is applied at edge S+n·(SETTLE_CYCLES+1)+1 and sampled at edge S+(n+1)·(SETTLE_CYCLES+1), where S is the start edge.
- LFSR next: {q[6:0], q[7]^q[5]^q[4]^q[3]}. This is maximal length, period 255, and never reaches 0.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE and while busy.
- tile_ui, signature and last_uo hold their values in IDLE.

Optional Feature:
- Macro: TILE_SEQ_COMPARE_EN.
- When defined:
  - adds input expected_sig[15:0] and output pass (1 bit);
  - at the edge entering DONE, pass <= (final signature == expected_sig);
  - pass clears to 0 on reset and on start;
  - expected_sig must be stable from start to done.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Zero seed, zero response: SETTLE_CYCLES=2, seed=8'h00, vec_count=1, tile_uo=8'h00, start pulse at edge 0 -> tile_ui=8'h01 from edge 1; busy=1 from edge 1 to edge 3; done pulses in the cycle after edge 3; signature=16'hFFFE; last_uo=8'h00.
- Non-zero response: same setup with tile_uo=8'h5A -> signature=16'hFFA4, last_uo=8'h5A.
- Vector sequence: seed=8'h01, vec_count=5 -> tile_ui sequence 01,02,04,08,11, each held 3 cycles; exactly 5 captures; single done pulse.
- Full-length run: vec_count=0, seed=8'hA5 -> 256 captures; the 256th applied vector equals 8'hA5 (period 255 wrap); done occurs 256·3 cycles after start.
- Reset and ignored start: rst asserted during vector 2 of a 5-vector run -> next edge: IDLE, tile_ui=0, signature=FFFF, no done. A separate start pulse while busy -> no restart and no change to the timing above.
- Compare (TILE_SEQ_COMPARE_EN): expected_sig=16'hFFA4 with the tile_uo=8'h5A case -> pass=1 at done; expected_sig=16'h0000 -> pass=0.
